// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler framing one payload byte per grant as SOF/ID/DATA[/CSUM] into a UART TX FIFO.
// Latency: handshake cycle, then one byte per cycle; frame_done pulses after the last push. Optional: UART_SCHED_CHECKSUM_EN.
module uart_tx_scheduler #(
  parameter int          NUM_REQ  = 4,
  parameter logic [7:0]  SOF_BYTE = 8'hAA
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   tx_full,
  output logic                   tx_push,
  output logic [7:0]             tx_push_data,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic                   frame_done
);

`ifdef UART_SCHED_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_SOF, S_ID, S_DATA, S_CSUM} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SOF, S_ID, S_DATA} state_t;
`endif

  state_t       state_q, state_d;
  logic [2:0]   grant_id_q, grant_id_d;
  logic [2:0]   last_grant_q, last_grant_d;
  logic [7:0]   payload_q, payload_d;
  logic         busy_q, busy_d;
  logic         frame_done_q, frame_done_d;

  logic               arb_found;
  logic [2:0]         arb_gnt;
  logic [NUM_REQ-1:0] arb_oh;
  logic [7:0]         arb_byte;
  int                 arb_idx;

  // Search begins one past the previous winner so a persistent requester yields to the others.
  always_comb begin
    arb_found = 1'b0;
    arb_gnt   = '0;
    arb_oh    = '0;
    arb_byte  = '0;
    arb_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!arb_found && req_valid[arb_idx]) begin
        arb_found       = 1'b1;
        arb_gnt         = 3'(arb_idx);
        arb_oh[arb_idx] = 1'b1;
        arb_byte        = req_data[8*arb_idx +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    payload_d    = payload_q;
    frame_done_d = 1'b0;
    req_ready    = '0;
    tx_push      = 1'b0;
    tx_push_data = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (arb_found && !reset) begin
          req_ready    = arb_oh;
          payload_d    = arb_byte;
          grant_id_d   = arb_gnt;
          last_grant_d = arb_gnt;
          state_d      = S_SOF;
        end
      end
      S_SOF: begin
        tx_push      = ~tx_full;
        tx_push_data = SOF_BYTE;
        if (tx_push) state_d = S_ID;
      end
      S_ID: begin
        tx_push      = ~tx_full;
        tx_push_data = {5'b0, grant_id_q};
        if (tx_push) state_d = S_DATA;
      end
      S_DATA: begin
        tx_push      = ~tx_full;
        tx_push_data = payload_q;
`ifdef UART_SCHED_CHECKSUM_EN
        if (tx_push) state_d = S_CSUM;
      end
      S_CSUM: begin
        tx_push      = ~tx_full;
        tx_push_data = SOF_BYTE ^ {5'b0, grant_id_q} ^ payload_q;
`endif
        if (tx_push) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= 3'(NUM_REQ - 1);
      payload_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      payload_q    <= payload_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = busy_q;
  assign grant_id   = grant_id_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: frame table plus round-robin, backpressure and reset sequences.
module tb_uart_tx_scheduler;

`ifdef UART_SCHED_CHECKSUM_EN
  localparam int FL = 4;
`else
  localparam int FL = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_full;
  logic        tx_push;
  logic [7:0]  tx_push_data;
  logic        busy;
  logic [2:0]  grant_id;
  logic        frame_done;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]       valid;
    logic [31:0]      data;
    int               g;
    logic [3:0][7:0]  bytes;  // {csum, data, id, sof}
  } vec_t;

  vec_t tbl [5];

  uart_tx_scheduler #(.NUM_REQ(4), .SOF_BYTE(8'hAA)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_full(tx_full), .tx_push(tx_push),
    .tx_push_data(tx_push_data), .busy(busy), .grant_id(grant_id),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot(input int g);
    return 1 << g;
  endfunction

  // Starts in IDLE just after an edge; leaves one cycle after the frame_done pulse.
  task automatic run_frame(input vec_t v);
    req_valid = v.valid;
    req_data  = v.data;
    tx_full   = 1'b0;
    #1;
    chk("ready_grant", int'(req_ready), onehot(v.g));
    tick();
    req_valid = 4'b0000;
    #1;
    for (int i = 0; i < FL; i++) begin
      chk("push_strobe", int'(tx_push), 1);
      chk("push_byte", int'(tx_push_data), int'(v.bytes[i]));
      chk("busy_in_frame", int'(busy), 1);
      tick();
    end
    chk("frame_done", int'(frame_done), 1);
    chk("grant_id", int'(grant_id), v.g);
    chk("busy_after", int'(busy), 0);
    tick();
    chk("done_pulse_once", int'(frame_done), 0);
  endtask

  initial begin
    tbl[0] = '{4'b0100, 32'h005C_0000, 2, {8'hF4, 8'h5C, 8'h02, 8'hAA}};
    tbl[1] = '{4'b1111, 32'h4433_2211, 3, {8'hED, 8'h44, 8'h03, 8'hAA}};
    tbl[2] = '{4'b0011, 32'h0000_B2A1, 0, {8'h0B, 8'hA1, 8'h00, 8'hAA}};
    tbl[3] = '{4'b1010, 32'h0000_7E00, 1, {8'hD5, 8'h7E, 8'h01, 8'hAA}};
    tbl[4] = '{4'b1010, 32'hFF00_1200, 3, {8'h56, 8'hFF, 8'h03, 8'hAA}};

    reset = 1'b1; req_valid = 4'b0; req_data = 32'h0; tx_full = 1'b0;
    tick(); tick();
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_push", int'(tx_push), 0);
    chk("rst_data", int'(tx_push_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_done", int'(frame_done), 0);
    reset = 1'b0;
    tick();

    // Round-robin with everyone valid, frames back-to-back.
    req_valid = 4'b1111;
    req_data  = 32'h4433_2211;
    #1;
    for (int f = 0; f < 8; f++) begin
      int ones;
      chk("rr_ready", int'(req_ready), onehot(f % 4));
      if (f > 0) chk("rr_done_same_cycle", int'(frame_done), 1);
      ones = 0;
      tick();
      for (int i = 0; i < FL; i++) begin
        if (req_ready != 4'b0) ones++;
        chk("rr_push", int'(tx_push), 1);
        if (i == 0) chk("rr_sof_no_gap", int'(tx_push_data), 8'hAA);
        if (i == 2) chk("rr_payload", int'(tx_push_data), 8'h11 * (f % 4 + 1));
        tick();
      end
      chk("rr_ready_quiet", ones, 0);
      chk("rr_grant_id", int'(grant_id), f % 4);
    end
    req_valid = 4'b0;
    tick();

    for (int t = 0; t < 5; t++) run_frame(tbl[t]);

    // Backpressure: three stalled cycles in DATA.
    req_valid = 4'b0001; req_data = 32'h0000_003C;
    #1;
    chk("bp_ready", int'(req_ready), 1);
    tick();
    req_valid = 4'b0;
    tick(); tick();
    tx_full = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("bp_push_held", int'(tx_push), 0);
      chk("bp_data_held", int'(tx_push_data), 8'h3C);
      chk("bp_busy", int'(busy), 1);
      tick();
    end
    tx_full = 1'b0;
    #1;
    chk("bp_push_release", int'(tx_push), 1);
    chk("bp_payload", int'(tx_push_data), 8'h3C);
    tick();
`ifdef UART_SCHED_CHECKSUM_EN
    chk("bp_csum", int'(tx_push_data), 8'hAA ^ 8'h3C);
    chk("bp_no_dup", int'(frame_done), 0);
    tick();
`endif
    chk("bp_done", int'(frame_done), 1);
    tick();

    // Reset mid-frame while in ID.
    req_valid = 4'b1111; req_data = 32'h4433_2211;
    #1;
    chk("mr_ready", int'(req_ready), onehot(1));
    tick();
    req_valid = 4'b0;
    tick();
    chk("mr_in_id", int'(tx_push_data), 8'h01);
    reset = 1'b1;
    #1;
    chk("mr_push", int'(tx_push), 0);
    chk("mr_data", int'(tx_push_data), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_grant", int'(grant_id), 0);
    chk("mr_done", int'(frame_done), 0);
    tick();
    reset = 1'b0;
    tick();
    run_frame('{4'b1111, 32'h4433_2211, 0, {8'hBB, 8'h11, 8'h00, 8'hAA}});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin frame scheduler that shares the UART transmit path between `NUM_REQ` on-chip requesters, such as traffic-state reporters and camera event sources. It accepts one payload byte per granted request and frames it as SOF, ID, DATA and optional CHECKSUM. The frame is pushed byte-by-byte into the UART controller's TX FIFO write port (`tx_push`/`tx_push_data`), honouring `tx_full`. The block sits between the application logic and the UART controller.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `SOF_BYTE`, default 8'hAA: start-of-frame marker.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i has a payload pending.
- `req_data`  in  NUM_REQ*8  payload bytes; requester i occupies bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot handshake; payload i is consumed on a cycle where `req_valid[i] & req_ready[i]`.
- `tx_full`  in  1  TX FIFO full, from the UART controller.
- `tx_push`  out  1  TX FIFO write strobe.
- `tx_push_data`  out  8  byte to write.
- `busy`  out  1  a frame is in progress (state != IDLE).
- `grant_id`  out  3  index of the requester whose frame is in progress; holds its value after the frame ends.
- `frame_done`  out  1  one-cycle pulse after the last byte of a frame is pushed.

## Operation
- FSM states: IDLE, SOF, ID, DATA, CSUM. Reset state is IDLE.
- **Arbitration (IDLE):**
  - If any `req_valid` is set, search starts at `last_grant+1` mod NUM_REQ. The first valid index g wins.
  - `req_ready[g]` is driven combinationally in that same cycle.
  - On that edge: latch `req_data[g]` into the payload register, set `grant_id=g` and `last_grant=g`, and go to SOF.
  - If no request is valid, `req_ready` stays 0 and the FSM stays in IDLE.
- `req_ready` is 0 in every non-IDLE state. Requesters must hold `req_valid` and `req_data` stable until they see ready.
- **Emit states:**
  - `tx_push = ~tx_full` (combinational).
  - `tx_push_data`: SOF gives SOF_BYTE; ID gives {5'b0, grant_id}; DATA gives the payload; CSUM gives SOF_BYTE ^ {5'b0,grant_id} ^ payload.
  - The FSM advances only on a cycle where `tx_push=1`. While `tx_full=1` it holds its state and data, and no byte is lost or duplicated.
- **Frame end:** after the last byte (CSUM, or DATA when checksum is compiled out), return to IDLE and set `frame_done=1` for exactly one cycle.
- **Priority rotation:** `last_grant` resets to NUM_REQ-1, so requester 0 has first priority after reset. If a requester is persistently valid, it cannot be granted twice while any other requester is valid.
- **Reset mid-frame:** all state clears asynchronously and any partial frame is abandoned. The TX FIFO shares the same reset.
- **Reset values:** `req_ready=0`, `tx_push=0`, `tx_push_data=8'h00`, `busy=0`, `grant_id=0`, `frame_done=0`. Internally, the payload register is 0 and `last_grant=NUM_REQ-1`.

## Timing
- **Handshake:** in cycle 0, the IDLE handshake completes.
- **Pushes:** with `tx_full=0` throughout, bytes are pushed on cycles 1, 2, 3 and 4 (cycles 1, 2 and 3 without checksum).
- **Frame completion:** `frame_done` and IDLE are observed at cycle 5 (4 without checksum). A new handshake can occur in that same cycle.
- **Throughput:** one frame per 5 cycles (4 without checksum).
- **Stalls:** each cycle of `tx_full=1` during emit adds exactly one cycle of latency.
- **Output registering:** `busy`, `grant_id` and `frame_done` are registered. `req_ready`, `tx_push` and `tx_push_data` are combinational from state/registers and inputs, with no combinational path from `tx_push_data` to inputs.

## Configuration
- Macro `UART_SCHED_CHECKSUM_EN`.
- **Defined:** CSUM state is present and frames are 4 bytes (SOF, ID, DATA, XOR checksum).
- **Undefined:** the CSUM state and checksum logic are removed, frames are 3 bytes, and DATA transitions directly to IDLE with a `frame_done` pulse.

## Test plan
- **Single request:** `req_valid=4'b0100`, `req_data[23:16]=8'h5C`, `tx_full=0`.
  - With checksum: pushes AA, 02, 5C, F4 on consecutive cycles, then a `frame_done` pulse with `grant_id=2`.
  - Without checksum: pushes AA, 02, 5C.
- **Round-robin:** all four `req_valid` held high over 8 frames. Grant order is 0, 1, 2, 3, 0, 1, 2, 3, and `req_ready` is one-hot exactly once per frame.
- **Backpressure:** hold `tx_full=1` for 3 cycles in the DATA state. `tx_push=0` while it is held, the payload byte is pushed exactly once after release, and the frame completes 3 cycles late.
- **Skip idle requesters:** `last_grant=0`, and only `req_valid[3]` and `req_valid[1]` are set. Requester 1 is granted first, then requester 3.
- **Reset mid-frame:** assert `reset` in the ID state. All outputs return to their reset values immediately. After release, requester 0 wins if it is valid together with others.
- **Back-to-back frames:** a new request is accepted in the same cycle as `frame_done`, and its SOF is pushed on the next cycle with no gap.
